// File: rtl/miner_pkg.sv
// miner_pkg: shared state encoding, block padding constants and the
// digest byte-reversal helper used by the hash sequencer.
package miner_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_B1_ISSUE = 4'd1,
    ST_B1_WAIT  = 4'd2,
    ST_B2_ISSUE = 4'd3,
    ST_B2_WAIT  = 4'd4,
    ST_H2_ISSUE = 4'd5,
    ST_H2_WAIT  = 4'd6,
    ST_COMPARE  = 4'd7,
    ST_FOUND    = 4'd8
  } miner_state_e;

  // Padding half of the hash-of-hash block: 0x80 marker, length 256 bits.
  localparam logic [255:0] HASH2_PAD_DEFAULT = {8'h80, 232'h0, 16'h0100};

  // Second header block: marker word after the nonce, then zeros and the
  // 640-bit message length.
  localparam logic [31:0]  BLK2_MARK = 32'h8000_0000;
  localparam logic [351:0] BLK2_PAD  = {336'h0, 16'h0280};

  // Reverse the byte order of a 256-bit digest.
  function automatic logic [255:0] bswap256(input logic [255:0] d);
    logic [255:0] r;
    r = 256'd0;
    for (int i = 0; i < 32; i++) begin
      r[8*i +: 8] = d[255-8*i -: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/miner_target_cmp.sv
// miner_target_cmp: byte-reverses the final digest and compares it against
// the job target. The result is registered, giving a fixed one-cycle latency.
module miner_target_cmp
  import miner_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [255:0] digest_i,
  input  logic [255:0] target_i,
  output logic         le_o
);

  logic le_q;
  logic le_d;

  // Evaluate the compare only when a new final digest is presented.
  always_comb begin
    le_d = le_q;
    if (load_i) begin
      le_d = (bswap256(digest_i) <= target_i);
    end else begin
      le_d = le_q;
    end
  end

  // Hold the compare result until the next final digest.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      le_q <= 1'b0;
    end else begin
      le_q <= le_d;
    end
  end

  assign le_o = le_q;

endmodule

// File: rtl/miner_hash_sequencer.sv
// miner_hash_sequencer: drives one shared sha256_core through the double
// SHA-256 of an 80-byte header for each nonce of an inclusive range.
// Optional build macro MINER_HASH_COUNTER_EN adds the hash_count output.
module miner_hash_sequencer
  import miner_pkg::*;
#(
  parameter logic [255:0] HASH2_PAD  = HASH2_PAD_DEFAULT,
  parameter int unsigned  RST_CYCLES = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  input  logic [511:0] blk1,
  input  logic [95:0]  header_tail,
  input  logic [31:0]  nonce_start,
  input  logic [31:0]  nonce_end,
  input  logic [255:0] target,
  output logic         busy,
  output logic         found,
  output logic         exhausted,
  output logic [31:0]  golden_nonce,
  output logic [255:0] hash_out,
  output logic         sha_reset_n,
  output logic         sha_init,
  output logic         sha_next,
  output logic         sha_mode,
  output logic [511:0] sha_block,
`ifdef MINER_HASH_COUNTER_EN
  output logic [31:0]  hash_count,
`endif
  input  logic         sha_ready,
  input  logic         sha_digest_valid,
  input  logic [255:0] sha_digest
);

  localparam logic [7:0] RST_LAST = 8'(RST_CYCLES - 1);

  miner_state_e state_q, state_d;

  logic [7:0]   rst_cnt_q;
  logic         sha_reset_n_q;
  logic         busy_q, busy_d;
  logic         found_q, found_d;
  logic         exhausted_q, exhausted_d;
  logic [31:0]  golden_q, golden_d;
  logic [255:0] hash_out_q, hash_out_d;
  logic         sha_init_q, sha_init_d;
  logic         sha_next_q, sha_next_d;
  logic [511:0] sha_block_q, sha_block_d;
  logic         seen_q, seen_d;
  logic [31:0]  nonce_q, nonce_d;
  logic [31:0]  nonce_end_q, nonce_end_d;
  logic [511:0] blk1_q, blk1_d;
  logic [95:0]  tail_q, tail_d;
  logic [255:0] target_q, target_d;
  logic [255:0] d2_q, d2_d;
`ifdef MINER_HASH_COUNTER_EN
  logic [31:0]  hash_cnt_q, hash_cnt_d;
`endif

  logic accept_s;
  logic cmpl_s;
  logic cmp_load_s;
  logic cmp_le_s;

  // A new job is taken only when idle or parked on a hit, with the core out
  // of reset; abort wins over a simultaneous start.
  assign accept_s = start & sha_reset_n_q & ~abort &
                    ((state_q == ST_IDLE) | (state_q == ST_FOUND));

  // Completion needs the core to have gone busy since the issue pulse, so a
  // digest left over from the previous operation is never taken.
  assign cmpl_s = seen_q & sha_ready & sha_digest_valid;

  miner_target_cmp u_cmp (
    .clk_i    (clock),
    .rst_i    (reset),
    .load_i   (cmp_load_s),
    .digest_i (sha_digest),
    .target_i (target_q),
    .le_o     (cmp_le_s)
  );

  // Hold the core in reset for RST_CYCLES cycles after our own reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      rst_cnt_q     <= 8'd0;
      sha_reset_n_q <= 1'b0;
    end else if (!sha_reset_n_q) begin
      if (rst_cnt_q == RST_LAST) begin
        sha_reset_n_q <= 1'b1;
      end else begin
        rst_cnt_q <= rst_cnt_q + 8'd1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:     state_d = accept_s ? ST_B1_ISSUE : ST_IDLE;
        ST_B1_ISSUE: state_d = sha_ready ? ST_B1_WAIT : ST_B1_ISSUE;
        ST_B1_WAIT:  state_d = cmpl_s ? ST_B2_ISSUE : ST_B1_WAIT;
        ST_B2_ISSUE: state_d = ST_B2_WAIT;
        ST_B2_WAIT:  state_d = cmpl_s ? ST_H2_ISSUE : ST_B2_WAIT;
        ST_H2_ISSUE: state_d = ST_H2_WAIT;
        ST_H2_WAIT:  state_d = cmpl_s ? ST_COMPARE : ST_H2_WAIT;
        ST_COMPARE: begin
          if (cmp_le_s) begin
            state_d = ST_FOUND;
          end else if (nonce_q == nonce_end_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_B1_ISSUE;
          end
        end
        ST_FOUND:    state_d = accept_s ? ST_B1_ISSUE : ST_FOUND;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs and datapath next values.
  always_comb begin
    busy_d      = (state_d != ST_IDLE) && (state_d != ST_FOUND);
    found_d     = found_q;
    exhausted_d = exhausted_q;
    golden_d    = golden_q;
    hash_out_d  = hash_out_q;
    sha_init_d  = 1'b0;
    sha_next_d  = 1'b0;
    sha_block_d = sha_block_q;
    seen_d      = seen_q;
    nonce_d     = nonce_q;
    nonce_end_d = nonce_end_q;
    blk1_d      = blk1_q;
    tail_d      = tail_q;
    target_d    = target_q;
    d2_d        = d2_q;
    cmp_load_s  = 1'b0;
`ifdef MINER_HASH_COUNTER_EN
    hash_cnt_d  = hash_cnt_q;
`endif
    if (abort) begin
      seen_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_FOUND: begin
          if (accept_s) begin
            blk1_d      = blk1;
            tail_d      = header_tail;
            nonce_d     = nonce_start;
            nonce_end_d = nonce_end;
            target_d    = target;
            found_d     = 1'b0;
            exhausted_d = 1'b0;
            sha_block_d = blk1;
`ifdef MINER_HASH_COUNTER_EN
            hash_cnt_d  = 32'd0;
`endif
          end else begin
            seen_d = 1'b0;
          end
        end
        ST_B1_ISSUE: begin
          seen_d     = 1'b0;
          sha_init_d = sha_ready;
        end
        ST_B1_WAIT: begin
          seen_d = seen_q | ~sha_ready;
          if (cmpl_s) begin
            sha_block_d = {tail_q, nonce_q, BLK2_MARK, BLK2_PAD};
          end else begin
            sha_block_d = sha_block_q;
          end
        end
        ST_B2_ISSUE: begin
          seen_d     = 1'b0;
          sha_next_d = 1'b1;
        end
        ST_B2_WAIT: begin
          seen_d = seen_q | ~sha_ready;
          if (cmpl_s) begin
            // The upper half of the hash-of-hash block is d1.
            sha_block_d = {sha_digest, HASH2_PAD};
          end else begin
            sha_block_d = sha_block_q;
          end
        end
        ST_H2_ISSUE: begin
          seen_d     = 1'b0;
          sha_init_d = 1'b1;
        end
        ST_H2_WAIT: begin
          seen_d     = seen_q | ~sha_ready;
          cmp_load_s = cmpl_s;
          if (cmpl_s) begin
            d2_d = sha_digest;
          end else begin
            d2_d = d2_q;
          end
        end
        ST_COMPARE: begin
`ifdef MINER_HASH_COUNTER_EN
          if (hash_cnt_q != 32'hFFFF_FFFF) begin
            hash_cnt_d = hash_cnt_q + 32'd1;
          end else begin
            hash_cnt_d = hash_cnt_q;
          end
`endif
          if (cmp_le_s) begin
            golden_d   = nonce_q;
            hash_out_d = d2_q;
            found_d    = 1'b1;
          end else if (nonce_q == nonce_end_q) begin
            exhausted_d = 1'b1;
          end else begin
            // Increment is merged into the compare cycle; wraps mod 2^32.
            nonce_d     = nonce_q + 32'd1;
            sha_block_d = blk1_q;
          end
        end
        default: begin
          seen_d = 1'b0;
        end
      endcase
    end
  end

  // Register all outputs and job state.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q      <= 1'b0;
      found_q     <= 1'b0;
      exhausted_q <= 1'b0;
      golden_q    <= 32'd0;
      hash_out_q  <= 256'd0;
      sha_init_q  <= 1'b0;
      sha_next_q  <= 1'b0;
      sha_block_q <= 512'd0;
      seen_q      <= 1'b0;
      nonce_q     <= 32'd0;
      nonce_end_q <= 32'd0;
      blk1_q      <= 512'd0;
      tail_q      <= 96'd0;
      target_q    <= 256'd0;
      d2_q        <= 256'd0;
`ifdef MINER_HASH_COUNTER_EN
      hash_cnt_q  <= 32'd0;
`endif
    end else begin
      busy_q      <= busy_d;
      found_q     <= found_d;
      exhausted_q <= exhausted_d;
      golden_q    <= golden_d;
      hash_out_q  <= hash_out_d;
      sha_init_q  <= sha_init_d;
      sha_next_q  <= sha_next_d;
      sha_block_q <= sha_block_d;
      seen_q      <= seen_d;
      nonce_q     <= nonce_d;
      nonce_end_q <= nonce_end_d;
      blk1_q      <= blk1_d;
      tail_q      <= tail_d;
      target_q    <= target_d;
      d2_q        <= d2_d;
`ifdef MINER_HASH_COUNTER_EN
      hash_cnt_q  <= hash_cnt_d;
`endif
    end
  end

  assign busy         = busy_q;
  assign found        = found_q;
  assign exhausted    = exhausted_q;
  assign golden_nonce = golden_q;
  assign hash_out     = hash_out_q;
  assign sha_reset_n  = sha_reset_n_q;
  assign sha_init     = sha_init_q;
  assign sha_next     = sha_next_q;
  assign sha_mode     = 1'b1;
  assign sha_block    = sha_block_q;
`ifdef MINER_HASH_COUNTER_EN
  assign hash_count   = hash_cnt_q;
`endif

endmodule

// File: tb/tb_miner_hash_sequencer.sv
// Bench for miner_hash_sequencer with a behavioural SHA-256 core model.
module tb_miner_hash_sequencer;

  localparam logic [511:0] GEN_BLK1 = 512'h01000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_3ba3edfd_7a7b12b2_7ac72c3e_67768f61_7fc81bc3_888a5132_3a9fb8aa;
  localparam logic [95:0]  GEN_TAIL = 96'h4b1e5e4a_29ab5f49_ffff001d;
  localparam logic [255:0] GEN_TGT  = {32'h0, 16'hffff, 208'h0};
  localparam logic [255:0] GEN_HASH = 256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;
  localparam logic [255:0] PAD2     = {8'h80, 232'h0, 16'h0100};
  localparam logic [255:0] SHA_IV   = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [31:0] K_TAB [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic         clock = 1'b0;
  logic         reset, start, abort;
  logic [511:0] blk1;
  logic [95:0]  header_tail;
  logic [31:0]  nonce_start, nonce_end;
  logic [255:0] target;
  logic         busy, found, exhausted;
  logic [31:0]  golden_nonce;
  logic [255:0] hash_out;
  logic         sha_reset_n, sha_init, sha_next, sha_mode;
  logic [511:0] sha_block;
  logic         sha_ready, sha_digest_valid;
  logic [255:0] sha_digest;
`ifdef MINER_HASH_COUNTER_EN
  logic [31:0]  hash_count;
`endif

  int total = 0;
  int bad = 0;

  miner_hash_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .blk1(blk1), .header_tail(header_tail), .nonce_start(nonce_start), .nonce_end(nonce_end),
    .target(target), .busy(busy), .found(found), .exhausted(exhausted),
    .golden_nonce(golden_nonce), .hash_out(hash_out), .sha_reset_n(sha_reset_n),
    .sha_init(sha_init), .sha_next(sha_next), .sha_mode(sha_mode), .sha_block(sha_block),
`ifdef MINER_HASH_COUNTER_EN
    .hash_count(hash_count),
`endif
    .sha_ready(sha_ready), .sha_digest_valid(sha_digest_valid), .sha_digest(sha_digest));

  always #5 clock = ~clock;

  // ---------------- SHA-256 reference ----------------
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [0:63];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    logic [255:0] r;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
    a = hin[255:224]; b = hin[223:192]; c = hin[191:160]; d = hin[159:128];
    e = hin[127:96];  f = hin[95:64];   g = hin[63:32];   h = hin[31:0];
    for (int t = 0; t < 64; t++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K_TAB[t] + w[t];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    r = {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
         hin[127:96] + e,  hin[95:64] + f,   hin[63:32] + g,   hin[31:0] + h};
    return r;
  endfunction

  // ---------------- core model ----------------
  bit           stall_mode = 1'b0;
  int           core_phase, core_cnt;
  int           ignored = 0;
  logic [255:0] core_res;

  always @(posedge clock) begin
    if (!sha_reset_n) begin
      sha_ready <= 1'b1; sha_digest_valid <= 1'b0; sha_digest <= 256'd0;
      core_phase <= 0; core_cnt <= 0;
    end else begin
      if (core_phase != 0 && (sha_init || sha_next)) ignored <= ignored + 1;
      case (core_phase)
        0: if (sha_init || sha_next) begin
             core_res <= sha_init ? sha_compress(SHA_IV, sha_block) : sha_compress(sha_digest, sha_block);
             core_cnt <= stall_mode ? 70 : 8;
             if (stall_mode) core_phase <= 1;
             else begin core_phase <= 2; sha_ready <= 1'b0; sha_digest_valid <= 1'b0; end
           end
        1: begin core_phase <= 2; sha_ready <= 1'b0; sha_digest_valid <= 1'b0; end
        default: if (core_cnt <= 1) begin
                   sha_ready <= 1'b1; sha_digest_valid <= 1'b1; sha_digest <= core_res; core_phase <= 0;
                 end else core_cnt <= core_cnt - 1;
      endcase
    end
  end

  // ---------------- monitor ----------------
  logic [31:0]  visited [$];
  logic [255:0] d1_log [$];
  logic [255:0] gen_d1 [$];
  int  pulse_err = 0;
  int  init_cnt = 0;
  logic prev_init = 1'b0, prev_next = 1'b0;

  always @(posedge clock) begin
    if (sha_next) visited.push_back(sha_block[415:384]);
    if (sha_init && sha_block[255:0] == PAD2) d1_log.push_back(sha_block[511:256]);
    if (sha_init) init_cnt <= init_cnt + 1;
    if ((sha_init && prev_init) || (sha_next && prev_next)) pulse_err <= pulse_err + 1;
    prev_init <= sha_init;
    prev_next <= sha_next;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic start_job(input logic [31:0] s, input logic [31:0] e, input logic [255:0] tgt);
    @(negedge clock);
    nonce_start = s; nonce_end = e; target = tgt; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit done = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clock);
      if (found || exhausted) begin done = 1'b1; break; end
    end
    chk(tag, {255'd0, done}, 256'd1);
  endtask

  task automatic run_job(input string tag, input logic [31:0] s, input logic [31:0] e,
                         input logic [255:0] tgt, input int budget);
    visited.delete(); d1_log.delete();
    start_job(s, e, tgt);
    wait_done(tag, budget);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_found"}, found, 1'b0);
    chk({tag, "_exh"}, exhausted, 1'b0);
    chk({tag, "_golden"}, golden_nonce, 32'd0);
    chk({tag, "_hash"}, hash_out, 256'd0);
    chk({tag, "_init"}, sha_init, 1'b0);
    chk({tag, "_next"}, sha_next, 1'b0);
    chk({tag, "_block"}, sha_block[511:256], 256'd0);
    chk({tag, "_block_lo"}, sha_block[255:0], 256'd0);
    chk({tag, "_rstn"}, sha_reset_n, 1'b0);
  endtask

  task automatic count_reset_low(input string tag, input bit poke_start);
    int low = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      start = (poke_start && i == 0) ? 1'b1 : 1'b0;
      if (sha_reset_n) break;
      low++;
    end
    start = 1'b0;
    chk(tag, low, 4);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ic;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    blk1 = GEN_BLK1; header_tail = GEN_TAIL;
    nonce_start = 32'd0; nonce_end = 32'd0; target = 256'd0;

    // reset values and core reset release
    @(negedge clock); @(negedge clock);
    check_reset_outputs("rst");
    reset = 1'b0;
    count_reset_low("rst_low_cycles", 1'b0);
    chk("sha_mode", sha_mode, 1'b1);

    // abort beats start
    @(negedge clock); start = 1'b1; abort = 1'b1;
    @(negedge clock); start = 1'b0; abort = 1'b0;
    chk("abort_beats_start", busy, 1'b0);

    // genesis hit
    run_job("gen_done", 32'h1dac2b7a, 32'h1dac2b7f, GEN_TGT, 2000);
    chk("gen_found", found, 1'b1);
    chk("gen_exh", exhausted, 1'b0);
    chk("gen_busy", busy, 1'b0);
    chk("gen_golden", golden_nonce, 32'h1dac2b7c);
    chk("gen_hash", hash_out, GEN_HASH);
    chk("gen_compares", visited.size(), 3);
    chk("gen_n0", visited[0], 32'h1dac2b7a);
    chk("gen_n2", visited[2], 32'h1dac2b7c);
`ifdef MINER_HASH_COUNTER_EN
    chk("gen_hash_count", hash_count, 32'd3);
`endif
    gen_d1 = d1_log;

    // miss
    run_job("miss_done", 32'h1dac2b7d, 32'h1dac2b7e, GEN_TGT, 2000);
    chk("miss_exh", exhausted, 1'b1);
    chk("miss_found", found, 1'b0);
    chk("miss_compares", visited.size(), 2);
    chk("miss_golden_kept", golden_nonce, 32'h1dac2b7c);

    // wrap through zero
    run_job("wrap_done", 32'hffffffff, 32'h00000001, 256'd0, 2000);
    chk("wrap_exh", exhausted, 1'b1);
    chk("wrap_count", visited.size(), 3);
    chk("wrap_n0", visited[0], 32'hffffffff);
    chk("wrap_n1", visited[1], 32'h00000000);
    chk("wrap_n2", visited[2], 32'h00000001);

    // stalled core with stale valid
    stall_mode = 1'b1;
    run_job("stall_done", 32'h1dac2b7a, 32'h1dac2b7f, GEN_TGT, 5000);
    stall_mode = 1'b0;
    chk("stall_found", found, 1'b1);
    chk("stall_golden", golden_nonce, 32'h1dac2b7c);
    chk("stall_hash", hash_out, GEN_HASH);
    chk("stall_d1_count", d1_log.size(), 3);
    for (int i = 0; i < 3; i++) chk("stall_d1", d1_log[i], gen_d1[i]);

    // abort during B2_WAIT, then restart
    start_job(32'h1dac2b7a, 32'h1dac2b7f, GEN_TGT);
    ic = 0;
    while (!sha_next && ic < 500) begin @(negedge clock); ic++; end
    chk("abort_reach_b2", {255'd0, sha_next}, 256'd1);
    abort = 1'b1;
    @(negedge clock); abort = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_init", sha_init, 1'b0);
    chk("abort_next", sha_next, 1'b0);
    chk("abort_found", found, 1'b0);
    run_job("restart_done", 32'h1dac2b7a, 32'h1dac2b7f, GEN_TGT, 2000);
    chk("restart_found", found, 1'b1);
    chk("restart_golden", golden_nonce, 32'h1dac2b7c);
    chk("restart_hash", hash_out, GEN_HASH);
    @(negedge clock); abort = 1'b1;
    @(negedge clock); abort = 1'b0;
    chk("abort_found_sticky", found, 1'b1);
    chk("abort_golden_kept", golden_nonce, 32'h1dac2b7c);

    // reset during H2_WAIT
    start_job(32'h1dac2b7a, 32'h1dac2b7f, GEN_TGT);
    ic = 0;
    while (!(sha_init && sha_block[255:0] == PAD2) && ic < 500) begin @(negedge clock); ic++; end
    chk("reach_h2", {255'd0, sha_init}, 256'd1);
    @(negedge clock); @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_reset_outputs("midrst");
    reset = 1'b0;
    ic = init_cnt;
    count_reset_low("midrst_low_cycles", 1'b1);
    repeat (10) @(negedge clock);
    chk("midrst_start_ignored", busy, 1'b0);
    chk("midrst_no_issue", init_cnt, ic);

    chk("ignored_pulses", ignored, 0);
    chk("pulse_width", pulse_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
